mem_wb_skid: RTL and testbench

- Parametrised successor of the MEM/WB pipeline register.
- Carries the writeback bundle from MEM to WB: regfile write-enable, ALU result, load data, destination register and result-source select.
- Adds a valid/ready handshake with a one-entry skid buffer, so WB can stall without combinationally back-pressuring MEM.
- Adds a synchronous flush and suppresses writes to register 0.
- Sits between the memory stage and the writeback mux/regfile.

---
 rtl/mem_wb_skid.sv | 152 +++++++++++++++
 tb/tb_mem_wb_skid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
// MEM/WB writeback register with valid/ready handshake, optional one-entry skid
// buffer, synchronous flush and write suppression for register 0.
module mem_wb_skid #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int SRC_W          = 2,
    parameter int SKID_EN        = 1,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              validM,
    output logic              readyM,
    input  logic              Regfile_weM,
    input  logic [DATA_W-1:0] aluOutM,
    input  logic [DATA_W-1:0] readDataM,
    input  logic [ADDR_W-1:0] writeRegAddrM,
    input  logic [SRC_W-1:0]  regSrc_muxM,
    output logic              validW,
    input  logic              readyW,
    output logic              Regfile_weW,
    output logic [DATA_W-1:0] aluOutW,
    output logic [DATA_W-1:0] readDataW,
    output logic [ADDR_W-1:0] writeRegAddrW,
    output logic [SRC_W-1:0]  regSrc_muxW
);

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        logic [ADDR_W-1:0] addr;
        logic [SRC_W-1:0]  src;
    } wb_t;

    wb_t  in_w;
    wb_t  out_q, out_d;
    logic vld_w;

    assign in_w = '{we: Regfile_weM, alu: aluOutM, rdata: readDataM,
                    addr: writeRegAddrM, src: regSrc_muxM};

    generate
        if (SKID_EN != 0) begin : g_skid
            typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

            state_e state_q, state_d;
            wb_t    skid_q, skid_d;
            logic   rdy_q;
            logic   accept, consume;

            assign accept  = validM & rdy_q;
            assign consume = (state_q != S_EMPTY) & readyW;

            always_comb begin
                state_d = state_q;
                out_d   = out_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = S_EMPTY;
                end else begin
                    case (state_q)
                        S_EMPTY: begin
                            if (accept) begin
                                state_d = S_ONE;
                                out_d   = in_w;
                            end
                        end
                        S_ONE: begin
                            if (accept && consume) begin
                                out_d = in_w;
                            end else if (accept) begin
                                // WB stalled: park the new bundle behind the current one
                                state_d = S_FULL;
                                skid_d  = in_w;
                            end else if (consume) begin
                                state_d = S_EMPTY;
                            end
                        end
                        S_FULL: begin
                            if (consume) begin
                                state_d = S_ONE;
                                out_d   = skid_q;
                            end
                        end
                        default: state_d = S_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= S_EMPTY;
                    out_q   <= '0;
                    skid_q  <= '0;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    out_q   <= out_d;
                    skid_q  <= skid_d;
                    rdy_q   <= (state_d != S_FULL);
                end
            end

            assign readyM = rdy_q;
            assign vld_w  = (state_q != S_EMPTY);
        end else begin : g_single
            logic vld_q, vld_d;
            logic accept, consume;

            // Pass-through back-pressure: a consuming WB frees the slot this cycle
            assign readyM  = ~vld_q | readyW;
            assign accept  = validM & readyM;
            assign consume = vld_q & readyW;

            always_comb begin
                vld_d = vld_q;
                out_d = out_q;
                if (flush) begin
                    vld_d = 1'b0;
                end else if (accept) begin
                    vld_d = 1'b1;
                    out_d = in_w;
                end else if (consume) begin
                    vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q <= 1'b0;
                    out_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    out_q <= out_d;
                end
            end

            assign vld_w = vld_q;
        end
    endgenerate

    assign validW        = vld_w;
    assign Regfile_weW   = vld_w & out_q.we &
                           ~((ZERO_REG_GUARD != 0) && (out_q.addr == '0));
    assign aluOutW       = out_q.alu;
    assign readDataW     = out_q.rdata;
    assign writeRegAddrW = out_q.addr;
    assign regSrc_muxW   = out_q.src;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: skid build (SKID_EN=1) and single-stage build (SKID_EN=0).
module tb_mem_wb_skid;

    logic        clk, rst, flush, validM, Regfile_weM, readyW;
    logic [31:0] aluOutM, readDataM;
    logic [4:0]  writeRegAddrM;
    logic [1:0]  regSrc_muxM;

    logic        readyM, validW, Regfile_weW;
    logic [31:0] aluOutW, readDataW;
    logic [4:0]  writeRegAddrW;
    logic [1:0]  regSrc_muxW;

    logic        readyM_s, validW_s, Regfile_weW_s;
    logic [31:0] aluOutW_s, readDataW_s;
    logic [4:0]  writeRegAddrW_s;
    logic [1:0]  regSrc_muxW_s;

    int chk  = 0;
    int pass = 0;

    mem_wb_skid #(.SKID_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .validM(validM), .readyM(readyM),
        .Regfile_weM(Regfile_weM), .aluOutM(aluOutM), .readDataM(readDataM),
        .writeRegAddrM(writeRegAddrM), .regSrc_muxM(regSrc_muxM),
        .validW(validW), .readyW(readyW), .Regfile_weW(Regfile_weW),
        .aluOutW(aluOutW), .readDataW(readDataW),
        .writeRegAddrW(writeRegAddrW), .regSrc_muxW(regSrc_muxW)
    );

    mem_wb_skid #(.SKID_EN(0)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .validM(validM), .readyM(readyM_s),
        .Regfile_weM(Regfile_weM), .aluOutM(aluOutM), .readDataM(readDataM),
        .writeRegAddrM(writeRegAddrM), .regSrc_muxM(regSrc_muxM),
        .validW(validW_s), .readyW(readyW), .Regfile_weW(Regfile_weW_s),
        .aluOutW(aluOutW_s), .readDataW(readDataW_s),
        .writeRegAddrW(writeRegAddrW_s), .regSrc_muxW(regSrc_muxW_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] alu, input logic [4:0] addr, input logic we);
        validM        = 1'b1;
        aluOutM       = alu;
        readDataM     = ~alu;
        writeRegAddrM = addr;
        regSrc_muxM   = alu[1:0];
        Regfile_weM   = we;
    endtask

    task automatic do_reset();
        rst = 1'b0; validM = 1'b0; flush = 1'b0; readyW = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; readyW = 1'b1;
        send(32'hDEAD_BEEF, 5'd9, 1'b1);
        tick(); tick();
        chk++; if (validW !== 1'b0) $display("FAIL reset_validW: got %b want 0", validW); else pass++;
        chk++; if (readyM !== 1'b1) $display("FAIL reset_readyM: got %b want 1", readyM); else pass++;
        chk++; if (Regfile_weW !== 1'b0) $display("FAIL reset_we: got %b want 0", Regfile_weW); else pass++;
        chk++; if ({aluOutW, readDataW, writeRegAddrW, regSrc_muxW} !== '0)
            $display("FAIL reset_data: got %h/%h/%h/%h want 0", aluOutW, readDataW, writeRegAddrW, regSrc_muxW); else pass++;
        validM = 1'b0;
        rst = 1'b1;
        tick();
        chk++; if (validW !== 1'b0 || readyM !== 1'b1 || aluOutW !== 32'h0)
            $display("FAIL reset_release: got v=%b r=%b alu=%h want v=0 r=1 alu=0", validW, readyM, aluOutW); else pass++;
    endtask

    task automatic test_stream();
        readyW = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(i, 5'(i), 1'b1);
            tick();
            chk++; if (validW !== 1'b1 || aluOutW !== 32'(i))
                $display("FAIL stream_out%0d: got v=%b alu=%h want v=1 alu=%h", i, validW, aluOutW, i); else pass++;
            chk++; if (readyM !== 1'b1 || readDataW !== ~32'(i))
                $display("FAIL stream_rdy%0d: got r=%b rd=%h want r=1 rd=%h", i, readyM, readDataW, ~32'(i)); else pass++;
        end
        validM = 1'b0;
        tick();
        chk++; if (validW !== 1'b0) $display("FAIL stream_drain: got %b want 0", validW); else pass++;
    endtask

    task automatic test_stall();
        readyW = 1'b0;
        send(32'hA, 5'd1, 1'b1);
        tick();
        chk++; if (validW !== 1'b1 || aluOutW !== 32'hA || readyM !== 1'b1)
            $display("FAIL stall_a: got v=%b alu=%h r=%b want 1/a/1", validW, aluOutW, readyM); else pass++;
        send(32'hB, 5'd2, 1'b1);
        tick();
        chk++; if (aluOutW !== 32'hA || readyM !== 1'b0)
            $display("FAIL stall_full: got alu=%h r=%b want a/0", aluOutW, readyM); else pass++;
        send(32'hC, 5'd3, 1'b1);
        tick();
        chk++; if (aluOutW !== 32'hA || writeRegAddrW !== 5'd1 || readyM !== 1'b0)
            $display("FAIL stall_hold: got alu=%h addr=%h r=%b want a/1/0", aluOutW, writeRegAddrW, readyM); else pass++;
        validM = 1'b0; readyW = 1'b1;
        tick();
        chk++; if (validW !== 1'b1 || aluOutW !== 32'hB || readyM !== 1'b1)
            $display("FAIL stall_b: got v=%b alu=%h r=%b want 1/b/1", validW, aluOutW, readyM); else pass++;
        tick();
        chk++; if (validW !== 1'b0) $display("FAIL stall_empty: got %b want 0", validW); else pass++;
    endtask

    task automatic test_flush();
        readyW = 1'b0;
        send(32'hA, 5'd1, 1'b1); tick();
        send(32'hB, 5'd2, 1'b1); tick();
        send(32'hC, 5'd3, 1'b1); flush = 1'b1;
        tick();
        flush = 1'b0; validM = 1'b0;
        chk++; if (validW !== 1'b0 || Regfile_weW !== 1'b0 || readyM !== 1'b1)
            $display("FAIL flush_full: got v=%b we=%b r=%b want 0/0/1", validW, Regfile_weW, readyM); else pass++;
        readyW = 1'b1;
        tick();
        chk++; if (validW !== 1'b0 || aluOutW === 32'hC)
            $display("FAIL flush_no_c: got v=%b alu=%h want v=0, alu!=c", validW, aluOutW); else pass++;
        // flush while ONE with an acceptable incoming bundle
        readyW = 1'b0;
        send(32'hD, 5'd4, 1'b1); tick();
        send(32'hE, 5'd6, 1'b1); flush = 1'b1;
        tick();
        flush = 1'b0; validM = 1'b0;
        chk++; if (validW !== 1'b0 || Regfile_weW !== 1'b0)
            $display("FAIL flush_one: got v=%b we=%b want 0/0", validW, Regfile_weW); else pass++;
        tick();
        chk++; if (validW !== 1'b0) $display("FAIL flush_one_drop: got %b want 0", validW); else pass++;
    endtask

    task automatic test_zero_guard();
        readyW = 1'b1;
        send(32'h7, 5'd0, 1'b1);
        tick();
        chk++; if (validW !== 1'b1 || Regfile_weW !== 1'b0)
            $display("FAIL zero_guard_r0: got v=%b we=%b want 1/0", validW, Regfile_weW); else pass++;
        send(32'h8, 5'd5, 1'b1);
        tick();
        chk++; if (Regfile_weW !== 1'b1 || writeRegAddrW !== 5'd5)
            $display("FAIL zero_guard_r5: got we=%b addr=%h want 1/5", Regfile_weW, writeRegAddrW); else pass++;
        send(32'h9, 5'd5, 1'b0);
        tick();
        chk++; if (Regfile_weW !== 1'b0) $display("FAIL zero_guard_we0: got %b want 0", Regfile_weW); else pass++;
        validM = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        readyW = 1'b0;
        send(32'h1, 5'd1, 1'b1); tick();
        send(32'h2, 5'd2, 1'b1); tick();
        validM = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk++; if (validW !== 1'b0 || Regfile_weW !== 1'b0 || readyM !== 1'b1 || aluOutW !== 32'h0)
            $display("FAIL reset_mid: got v=%b we=%b r=%b alu=%h want 0/0/1/0", validW, Regfile_weW, readyM, aluOutW); else pass++;
        tick();
        rst = 1'b1;
        readyW = 1'b1;
        tick();
        chk++; if (validW !== 1'b0) $display("FAIL reset_mid_empty: got %b want 0", validW); else pass++;
    endtask

    task automatic test_single();
        do_reset();
        readyW = 1'b0;
        send(32'h11, 5'd3, 1'b1);
        tick();
        chk++; if (validW_s !== 1'b1 || aluOutW_s !== 32'h11)
            $display("FAIL single_load: got v=%b alu=%h want 1/11", validW_s, aluOutW_s); else pass++;
        chk++; if (readyM_s !== 1'b0) $display("FAIL single_bp: got %b want 0", readyM_s); else pass++;
        readyW = 1'b1;
        #1;
        chk++; if (readyM_s !== 1'b1) $display("FAIL single_comb_rdy: got %b want 1", readyM_s); else pass++;
        send(32'h22, 5'd4, 1'b1);
        tick();
        chk++; if (validW_s !== 1'b1 || aluOutW_s !== 32'h22 || Regfile_weW_s !== 1'b1)
            $display("FAIL single_replace: got v=%b alu=%h we=%b want 1/22/1", validW_s, aluOutW_s, Regfile_weW_s); else pass++;
        readyW = 1'b0;
        send(32'h33, 5'd5, 1'b1);
        tick();
        chk++; if (aluOutW_s !== 32'h22 || writeRegAddrW_s !== 5'd4)
            $display("FAIL single_stall: got alu=%h addr=%h want 22/4", aluOutW_s, writeRegAddrW_s); else pass++;
        validM = 1'b0; readyW = 1'b1;
        tick();
        chk++; if (validW_s !== 1'b0) $display("FAIL single_drain: got %b want 0", validW_s); else pass++;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; validM = 1'b0; readyW = 1'b0;
        Regfile_weM = 1'b0; aluOutM = '0; readDataM = '0;
        writeRegAddrM = '0; regSrc_muxM = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_zero_guard();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
